full_subtractor: RTL and testbench

Registered full subtractor. Computes D = A − B − b_in with borrow-out over a parameterizable operand width; WIDTH = 1 is the classic single-bit full subtractor. It sits in the datapath as a leaf arithmetic block. It can be chained through its borrow ports to build wider subtractors or used standalone. Results are captured on the clock edge and qualified by a valid flag.

---
 rtl/full_subtractor_pkg.sv | 4 +
 rtl/full_subtractor_cell.sv | 11 +
 rtl/full_subtractor.sv | 50 +++++
 tb/tb_full_subtractor.sv | 98 +++++++++
 4 files changed

// File: rtl/full_subtractor_pkg.sv
// full_subtractor_pkg: shared constants for the registered subtractor datapath
package full_subtractor_pkg;
    localparam logic DIFF_RST_BIT = 1'b0;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: combinational 1-bit full subtractor cell
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/full_subtractor.sv
// full_subtractor: registered WIDTH-bit subtractor D = A - B - bin with borrow-out and valid
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inb,
    output logic [WIDTH-1:0] outD,
    output logic             outb,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d, v_q, v_d;
    assign c[0] = inb;
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        full_subtractor_cell u_cell (
            .a   (inA[g]),
            .b   (inB[g]),
            .bin (c[g]),
            .d   (diff[g]),
            .bout(c[g+1])
        );
    end
    always_comb begin
        d_d = in_valid ? diff : d_q;
        b_d = in_valid ? c[WIDTH] : b_q;
        v_d = in_valid;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= {WIDTH{DIFF_RST_BIT}};
            b_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            d_q <= d_d;
            b_q <= b_d;
            v_q <= v_d;
        end
    end
    assign outD      = d_q;
    assign outb      = b_q;
    assign out_valid = v_q;
endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: directed scoreboard bench for 1-bit and 8-bit subtractor instances
module tb_full_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n, v1, a1, b1, bi1, d1, bo1, ov1;
    logic       v8, bi8, bo8, ov8;
    logic [7:0] a8, b8, d8;
    typedef struct packed {logic [7:0] d; logic b; logic v;} exp_t;
    exp_t q1[$], q8[$];
    exp_t m1 = '0, m8 = '0;
    int checks = 0, fails = 0;
    logic [1:0] tt [8];

    full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .inA(a1), .inB(b1), .inb(bi1),
        .outD(d1), .outb(bo1), .out_valid(ov1)
    );
    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .inA(a8), .inB(b8), .inb(bi8),
        .outD(d8), .outb(bo8), .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle on both instances, predict, then check one edge later.
    task automatic step(input logic r, input logic va, input logic aa, input logic ba, input logic bia,
                        input logic vb, input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [1:0] t;
        logic [8:0] u;
        exp_t e;
        rst_n = r; v1 = va; a1 = aa; b1 = ba; bi1 = bia;
        v8 = vb; a8 = a; b8 = b; bi8 = bi;
        t = {1'b0, aa} - {1'b0, ba} - {1'b0, bia};
        u = {1'b0, a} - {1'b0, b} - {8'b0, bi};
        if (!r) m1 = '0;
        else if (va) m1 = '{d: {7'b0, t[0]}, b: t[1], v: 1'b1};
        else m1.v = 1'b0;
        if (!r) m8 = '0;
        else if (vb) m8 = '{d: u[7:0], b: u[8], v: 1'b1};
        else m8.v = 1'b0;
        q1.push_back(m1);
        q8.push_back(m8);
        @(posedge clk);
        #1;
        e = q1.pop_front();
        chk("w1_d", {7'b0, d1}, e.d);
        chk("w1_b", {7'b0, bo1}, {7'b0, e.b});
        chk("w1_v", {7'b0, ov1}, {7'b0, e.v});
        e = q8.pop_front();
        chk("w8_d", d8, e.d);
        chk("w8_b", {7'b0, bo8}, {7'b0, e.b});
        chk("w8_v", {7'b0, ov8}, {7'b0, e.v});
    endtask

    initial begin
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        @(negedge clk);
        step(0, 1, 1, 0, 0, 1, 8'h01, 8'h00, 0);
        step(0, 1, 1, 0, 0, 1, 8'h01, 8'h00, 0);
        chk("rst_d8", d8, 8'h00);
        chk("rst_v1", {7'b0, ov1}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] k;
            k = 3'(i);
            step(1, 1, k[2], k[1], k[0], 1, 8'(i * 37), 8'(i * 53), k[0]);
            chk("truth", {6'b0, d1, bo1}, {6'b0, tt[i]});
        end
        step(1, 1, 0, 0, 0, 1, 8'h00, 8'h01, 0);
        chk("wrap_d", d8, 8'hFF);
        chk("wrap_b", {7'b0, bo8}, 8'h01);
        step(1, 1, 0, 1, 0, 1, 8'hA5, 8'h25, 1);
        chk("nobor_d", d8, 8'h7F);
        chk("nobor_b", {7'b0, bo8}, 8'h00);
        step(1, 0, 1, 0, 0, 0, 8'h10, 8'h80, 0);
        chk("hold_d", d8, 8'h7F);
        step(1, 0, 0, 0, 1, 0, 8'h33, 8'h11, 1);
        step(1, 1, 1, 0, 1, 1, 8'h33, 8'h11, 1);
        chk("resume_d", d8, 8'h21);
        step(1, 1, 0, 1, 1, 1, 8'h40, 8'h41, 0);
        step(0, 1, 1, 1, 0, 1, 8'h90, 8'h10, 0);
        chk("midrst_v", {7'b0, ov8}, 8'h00);
        step(1, 1, 1, 1, 1, 1, 8'h90, 8'h10, 0);
        chk("after_d", d8, 8'h80);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(1, r[0], r[1], r[2], r[3], r[4], r[15:8], r[23:16], r[5]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
